paddle_input: RTL

Conditions the raw player buttons for the Pong paddle logic. It synchronises and debounces `btn_up`/`btn_dwn` and emits clean levels and press pulses. Once per game tick it also produces an arbitrated move direction and a hold-time-based speed grade. It sits between the board button pins and the game-logic block, in the 25.125 MHz VGA clock domain, and uses the same `game_tick` strobe as the game logic.

---
 rtl/paddle_input.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/paddle_input.sv
// paddle_input: synchronises and debounces the paddle buttons, emits press pulses,
// and once per game tick arbitrates a move direction with a hold-time speed grade.
module paddle_input #(
   parameter int unsigned DB_CYCLES      = 250000,
   parameter int unsigned ACCEL1_TICKS   = 15,
   parameter int unsigned ACCEL2_TICKS   = 45,
   parameter bit          BTN_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       btn_up_raw,
   input  logic       btn_dwn_raw,
   output logic       up_lvl,
   output logic       dwn_lvl,
   output logic       up_press,
   output logic       dwn_press,
   output logic [1:0] move_dir,
   output logic [1:0] move_speed
);

   localparam int unsigned NB     = 2;
   localparam int unsigned CNT_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int unsigned HOLD_W = 8;

   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = '1;
   localparam logic [HOLD_W-1:0] ACCEL1   = HOLD_W'(ACCEL1_TICKS);
   localparam logic [HOLD_W-1:0] ACCEL2   = HOLD_W'(ACCEL2_TICKS);

   typedef enum logic [1:0] {
      DIR_NONE = 2'b00,
      DIR_UP   = 2'b01,
      DIR_DOWN = 2'b10
   } dir_e;

   // Bit 0 carries the up button, bit 1 the down button throughout.
   logic [NB-1:0]            raw_w;
   logic [NB-1:0]            sync1_q;
   logic [NB-1:0]            sync2_q;
   logic [NB-1:0][CNT_W-1:0] cnt_q;
   logic [NB-1:0][CNT_W-1:0] cnt_d;
   logic [NB-1:0]            lvl_q;
   logic [NB-1:0]            lvl_d;
   logic [NB-1:0]            lvl_dly_q;
   logic [NB-1:0]            press_q;
   logic [NB-1:0]            press_d;

   dir_e                     dir_q;
   dir_e                     dir_d;
   dir_e                     tick_dir;
   logic [HOLD_W-1:0]        hold_q;
   logic [HOLD_W-1:0]        hold_d;
   logic [1:0]               speed_q;
   logic [1:0]               speed_d;

   // Polarity is normalised ahead of the synchroniser so reset always means released.
   assign raw_w = {btn_dwn_raw, btn_up_raw} ^ {NB{BTN_ACTIVE_LOW}};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         cnt_q     <= '0;
         lvl_q     <= '0;
         lvl_dly_q <= '0;
         press_q   <= '0;
         dir_q     <= DIR_NONE;
         hold_q    <= '0;
         speed_q   <= '0;
      end else begin
         sync1_q   <= raw_w;
         sync2_q   <= sync1_q;
         cnt_q     <= cnt_d;
         lvl_q     <= lvl_d;
         lvl_dly_q <= lvl_q;
         press_q   <= press_d;
         dir_q     <= dir_d;
         hold_q    <= hold_d;
         speed_q   <= speed_d;
      end
   end

   // Debounce: the level flips only after DB_CYCLES consecutive disagreeing samples.
   always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      for (int unsigned b = 0; b < NB; b++) begin
         if (sync2_q[b] != lvl_q[b]) begin
            if (cnt_q[b] == CNT_MAX) begin
               lvl_d[b] = sync2_q[b];
            end else begin
               cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
         end
      end
   end

   assign press_d = lvl_q & ~lvl_dly_q;

   // Tick-time arbitration; a reversal or release restarts the hold count.
   always_comb begin
      case (lvl_q)
         2'b01:   tick_dir = DIR_UP;
         2'b10:   tick_dir = DIR_DOWN;
         default: tick_dir = DIR_NONE;
      endcase

      dir_d   = dir_q;
      hold_d  = hold_q;
      speed_d = speed_q;

      if (tick) begin
         dir_d = tick_dir;
         if ((tick_dir != DIR_NONE) && (tick_dir == dir_q)) begin
            hold_d = (hold_q == HOLD_MAX) ? HOLD_MAX : hold_q + HOLD_W'(1);
         end else begin
            hold_d = '0;
         end

         if (tick_dir == DIR_NONE) begin
            speed_d = 2'd0;
         end else if (hold_d < ACCEL1) begin
            speed_d = 2'd1;
         end else if (hold_d < ACCEL2) begin
            speed_d = 2'd2;
         end else begin
            speed_d = 2'd3;
         end
      end
   end

   assign up_lvl     = lvl_q[0];
   assign dwn_lvl    = lvl_q[1];
   assign up_press   = press_q[0];
   assign dwn_press  = press_q[1];
   assign move_dir   = dir_q;
   assign move_speed = speed_q;

endmodule
